// File: rtl/lcd_char_writer.sv
// Avalon-MM write-only front end for an HD44780-style character LCD: FIFO-buffered bytes, counter-timed RS/E strobes.
// Optional backlight control register on address 3 when LCD_BACKLIGHT_EN is defined.
`timescale 1ns/1ps
module lcd_char_writer #(
    parameter int FIFO_DEPTH   = 4,
    parameter int T_SETUP      = 2,
    parameter int T_EN         = 12,
    parameter int T_HOLD       = 2,
    parameter int T_CMD_WAIT   = 2000,
    parameter int T_CLEAR_WAIT = 82000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        write,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic [7:0]  lcd_data,
    output logic        lcd_rs,
    output logic        lcd_rw,
    output logic        lcd_en
`ifdef LCD_BACKLIGHT_EN
    ,
    output logic        lcd_blon
`endif
);

    localparam int AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int LW    = $clog2(FIFO_DEPTH + 1);
    localparam int TMAX1 = (T_SETUP > T_EN) ? T_SETUP : T_EN;
    localparam int TMAX2 = (TMAX1 > T_HOLD) ? TMAX1 : T_HOLD;
    localparam int TMAX3 = (TMAX2 > T_CMD_WAIT) ? TMAX2 : T_CMD_WAIT;
    localparam int TMAX  = (TMAX3 > T_CLEAR_WAIT) ? TMAX3 : T_CLEAR_WAIT;
    localparam int CW    = $clog2(TMAX + 1);

    // Counter reload values: each phase lasts (value + 1) cycles.
    localparam logic [CW-1:0] C_SETUP = CW'(T_SETUP - 1);
    localparam logic [CW-1:0] C_EN    = CW'(T_EN - 1);
    localparam logic [CW-1:0] C_HOLD  = CW'(T_HOLD - 1);
    localparam logic [CW-1:0] C_CMD   = CW'(T_CMD_WAIT - 1);
    localparam logic [CW-1:0] C_CLEAR = CW'(T_CLEAR_WAIT - 1);
    localparam logic [CW-1:0] C_ZERO  = {CW{1'b0}};

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_ENABLE = 3'd2,
        ST_HOLD   = 3'd3,
        ST_WAIT   = 3'd4
    } state_t;

    state_t          state_r;
    state_t          next_state_s;
    logic [CW-1:0]   cnt_r;
    logic [CW-1:0]   cnt_next_s;
    logic            en_next_s;
    logic            pop_s;

    logic [8:0]      mem_r [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_r;
    logic [AW-1:0]   rd_ptr_r;
    logic [LW-1:0]   level_r;
    logic            full_s;
    logic            empty_s;
    logic            push_req_s;
    logic            push_s;
    logic            ovf_set_s;
    logic            ovf_clr_s;
    logic            ovf_r;
    logic            busy_s;
    logic [4:0]      level_ext_s;
    logic [31:0]     status_s;

    logic [7:0]      lcd_data_r;
    logic            lcd_rs_r;
    logic            lcd_en_r;
    logic            clear_r;
    logic [31:0]     readdata_r;
    logic            unused_s;

    // Clear display (0x01) and return home (0x02/0x03) need the long execution delay.
    function automatic logic is_clear_home(input logic [8:0] entry);
        return (entry[8] == 1'b0) &&
               ((entry[7:0] == 8'h01) || (entry[7:0] == 8'h02) || (entry[7:0] == 8'h03));
    endfunction

    assign full_s      = (level_r == LW'(FIFO_DEPTH));
    assign empty_s     = (level_r == {LW{1'b0}});
    assign push_req_s  = write && (address[1] == 1'b0);
    assign push_s      = push_req_s && !full_s;
    assign ovf_set_s   = push_req_s && full_s;
    assign ovf_clr_s   = write && (address == 2'd2) && writedata[2];
    assign busy_s      = (state_r != ST_IDLE) || !empty_s;
    assign level_ext_s = 5'(level_r);
    assign status_s    = {23'd0, level_ext_s, 1'b0, ovf_r, full_s, busy_s};
    assign unused_s    = ^writedata[31:8];

    // FIFO storage; contents are don't-care until a pointer covers them.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= {address[0], writedata[7:0]};
        end
    end

    // FIFO pointers and fill level; push and pop may coincide.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            level_r  <= {LW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   level_r <= level_r + LW'(1);
                2'b01:   level_r <= level_r - LW'(1);
                default: level_r <= level_r;
            endcase
        end
    end

    // Sticky overflow flag; a set in the same cycle as a clear wins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ovf_r <= 1'b0;
        end else if (ovf_set_s) begin
            ovf_r <= 1'b1;
        end else if (ovf_clr_s) begin
            ovf_r <= 1'b0;
        end
    end

    // FSM state, phase counter and registered enable strobe.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r  <= ST_IDLE;
            cnt_r    <= C_ZERO;
            lcd_en_r <= 1'b0;
        end else begin
            state_r  <= next_state_s;
            cnt_r    <= cnt_next_s;
            lcd_en_r <= en_next_s;
        end
    end

    // Next-state logic: each timed phase ends when the counter reaches zero.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE:   next_state_s = empty_s ? ST_IDLE : ST_SETUP;
            ST_SETUP:  next_state_s = (cnt_r == C_ZERO) ? ST_ENABLE : ST_SETUP;
            ST_ENABLE: next_state_s = (cnt_r == C_ZERO) ? ST_HOLD : ST_ENABLE;
            ST_HOLD:   next_state_s = (cnt_r == C_ZERO) ? ST_WAIT : ST_HOLD;
            ST_WAIT:   next_state_s = (cnt_r == C_ZERO) ? ST_IDLE : ST_WAIT;
            default:   next_state_s = ST_IDLE;
        endcase
    end

    // Output logic: pop request, counter reload on phase entry, next enable level.
    always_comb begin
        pop_s      = 1'b0;
        cnt_next_s = cnt_r;
        en_next_s  = 1'b0;
        if ((state_r == ST_IDLE) && !empty_s) begin
            pop_s = 1'b1;
        end else begin
            pop_s = 1'b0;
        end
        if (next_state_s != state_r) begin
            case (next_state_s)
                ST_SETUP:  cnt_next_s = C_SETUP;
                ST_ENABLE: cnt_next_s = C_EN;
                ST_HOLD:   cnt_next_s = C_HOLD;
                ST_WAIT:   cnt_next_s = clear_r ? C_CLEAR : C_CMD;
                default:   cnt_next_s = C_ZERO;
            endcase
        end else if (cnt_r != C_ZERO) begin
            cnt_next_s = cnt_r - CW'(1);
        end else begin
            cnt_next_s = cnt_r;
        end
        en_next_s = (next_state_s == ST_ENABLE);
    end

    // LCD bus latches the popped entry and holds it through IDLE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lcd_data_r <= 8'h00;
            lcd_rs_r   <= 1'b0;
            clear_r    <= 1'b0;
        end else if (pop_s) begin
            lcd_data_r <= mem_r[rd_ptr_r][7:0];
            lcd_rs_r   <= mem_r[rd_ptr_r][8];
            clear_r    <= is_clear_home(mem_r[rd_ptr_r]);
        end
    end

`ifdef LCD_BACKLIGHT_EN
    logic blon_r;

    // Backlight register, independent of the FIFO and FSM.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blon_r <= 1'b0;
        end else if (write && (address == 2'd3)) begin
            blon_r <= writedata[0];
        end
    end

    assign lcd_blon = blon_r;
`endif

    // Read mux registered every cycle, without read-strobe qualification.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata_r <= 32'd0;
        end else begin
            case (address)
                2'd2:    readdata_r <= status_s;
`ifdef LCD_BACKLIGHT_EN
                2'd3:    readdata_r <= {31'd0, blon_r};
`endif
                default: readdata_r <= 32'd0;
            endcase
        end
    end

    assign readdata = readdata_r;
    assign lcd_data = lcd_data_r;
    assign lcd_rs   = lcd_rs_r;
    assign lcd_en   = lcd_en_r;
    assign lcd_rw   = 1'b0;

endmodule

// File: doc/lcd_char_writer.md
Name: lcd_char_writer

Overview:
- Avalon-MM slave that accepts command and character bytes from the Nios II bus and drives an HD44780-style character LCD over its 8-bit parallel write interface.
- Handles the output direction of the LCD subsystem, alongside the read-only button input port.
- Buffers writes in a small FIFO and generates RS/E timing and post-write execution delays from cycle counters, so software only polls a status word.

Parameters:
- FIFO_DEPTH, 4: entries in the write FIFO; power of 2, 2..16.
- T_SETUP, 2: clk cycles RS/data are stable before E rises.
- T_EN, 12: clk cycles E is held high.
- T_HOLD, 2: clk cycles RS/data are held after E falls.
- T_CMD_WAIT, 2000: idle cycles after a normal command or data byte.
- T_CLEAR_WAIT, 82000: idle cycles after a clear/home command (RS=0, byte 0x01, 0x02 or 0x03).

Ports:
- clk  in  1  clock
- reset_n  in  1  reset, asynchronous, active-low
- address  in  2  0 = command write, 1 = data write, 2 = status/control
- write  in  1  Avalon write strobe, single cycle, no waitrequest
- writedata  in  32  only bits [7:0] used
- readdata  out  32  registered read mux
- lcd_data  out  8  LCD DB7..DB0
- lcd_rs  out  1  0 = command, 1 = data
- lcd_rw  out  1  tied 0 (write only)
- lcd_en  out  1  LCD enable strobe

Behaviour:
- Reset is asynchronous (reset_n low), clocked on clk. Reset values:
  - readdata = 0, lcd_data = 0, lcd_rs = 0, lcd_rw = 0, lcd_en = 0.
  - FIFO empty, FSM in IDLE, overflow flag = 0.
- Assertion mid-transfer drops E immediately and discards all FIFO contents.
- Push:
  - write with address 0 pushes {rs=0, writedata[7:0]}.
  - write with address 1 pushes {rs=1, writedata[7:0]}.
  - A push is accepted only if the FIFO is not full at the start of the cycle. Otherwise the word is dropped and overflow is set, even if a pop occurs in the same cycle.
- Status (address 2):
  - Read: bit0 busy (FSM != IDLE or FIFO non-empty), bit1 full, bit2 overflow, bits[8:4] FIFO level, other bits 0.
  - Write with writedata[2]=1 clears overflow. If a set and a clear land in the same cycle, set wins.
- readdata is updated every clk from the mux on address, with no read-strobe qualification, so it is valid 1 cycle after address is stable. Address 3 and addresses 0/1 read as 0.
- FSM:
  - IDLE: if the FIFO is non-empty, pop it, load lcd_data/lcd_rs, load the counter and go to SETUP. A push and a pop in the same cycle are both honoured.
  - SETUP: lcd_en = 0 for T_SETUP cycles, then ENABLE.
  - ENABLE: lcd_en = 1 for exactly T_EN cycles, then HOLD.
  - HOLD: lcd_en = 0, data held for T_HOLD cycles, then WAIT.
  - WAIT: count T_CLEAR_WAIT if the popped entry was a clear/home command, else T_CMD_WAIT, then IDLE.
- lcd_data/lcd_rs keep their last value in IDLE. lcd_en is registered (glitch-free).
- A single down-counter serves all phases, sized to $clog2(max of all timing parameters + 1).
- Back-to-back entries: the next pop happens on the first IDLE cycle after WAIT, so there are no idle gaps beyond the one IDLE cycle.
- FIFO pointers wrap modulo FIFO_DEPTH. Level is 0..FIFO_DEPTH.

Optional Feature:
- Macro LCD_BACKLIGHT_EN.
- When defined:
  - Adds output port lcd_blon (1 bit, reset 0).
  - Address 3 write sets lcd_blon = writedata[0], independent of the FIFO/FSM.
  - Address 3 read returns {31'b0, lcd_blon}.
- When undefined: no lcd_blon port, address 3 writes are ignored, address 3 reads return 0.

Test Plan (T_SETUP=2, T_EN=4, T_HOLD=2, T_CMD_WAIT=10, T_CLEAR_WAIT=40, FIFO_DEPTH=4):
- Reset, then write 0x41 to address 1 -> lcd_rs=1, lcd_data=0x41 at next IDLE exit. lcd_en high for exactly 4 cycles, starting 2 cycles after load. Status bit0=1 until IDLE returns (2+4+2+10 cycles after load).
- Write 0x01 to address 0 -> lcd_rs=0, one 4-cycle E pulse. busy stays 1 for 2+4+2+40 cycles after load.
- Write 6 data bytes back-to-back -> first is popped at once. Next 4 fill the FIFO (status bit1=1, level=4). The 6th is dropped and sets bit2. The output sequence is the first 5 bytes in order. Writing address 2 with 0x4 then reads bit2=0.
- Push and overflow-clear in the same cycle as a dropped push -> overflow reads 1.
- Assert reset_n low during ENABLE -> lcd_en=0 asynchronously, status reads 0 after release, no further E pulses.
- With LCD_BACKLIGHT_EN: write 1 to address 3 -> lcd_blon=1 next cycle, address 3 reads 0x1, and the data FIFO is unaffected.
